// File: rtl/core_read_master.sv
// ---------------------------------------------------------------------------
// core_read_master
//
// Avalon-MM pipelined read master. On Start_i it fetches a burst of N
// consecutive 512-bit lines starting at INITIAL_ADDR and streams them, in
// order, to the downstream read buffer with First/Last markers. A one-cycle
// Done_o pulse reports the end of the job.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   Start_i, LineCount_i,  job request (sampled only while idle);
//   AccuEn_i               AccuEn is driven onto address bit 63 for the job
//   Busy_o, Done_o         job status / one-cycle completion pulse
//   Avalon*                pipelined read master port (write side tied off)
//   ReadData_o,            head-of-buffer line and valid/ack handshake
//   ReadValid_o, ReadAck_i
//   First_o, Last_o        head line is the first / last line of the job
// ---------------------------------------------------------------------------
module core_read_master #(
    parameter logic [63:0] INITIAL_ADDR = 64'h0,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Start_i,
    input  logic [8:0]   LineCount_i,
    input  logic         AccuEn_i,
    output logic         Busy_o,
    output logic         Done_o,
    output logic [63:0]  AvalonAddr_o,
    output logic         AvalonRead_o,
    output logic         AvalonWrite_o,
    output logic [63:0]  AvalonByteEnable_o,
    output logic [511:0] AvalonWriteData_o,
    input  logic [511:0] AvalonReadData_i,
    input  logic         AvalonReadDataValid_i,
    output logic         AvalonLock_o,
    input  logic         AvalonWaitReq_i,
    output logic [511:0] ReadData_o,
    output logic         ReadValid_o,
    input  logic         ReadAck_i,
    output logic         First_o,
    output logic         Last_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int          PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [9:0]  DEPTH = 10'(FIFO_DEPTH);
    localparam logic [62:0] BASE  = INITIAL_ADDR[62:0];

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [9:0]       line_count;
    logic             accu;
    logic [9:0]       issued;
    logic [9:0]       received;
    logic [9:0]       delivered;
    logic [9:0]       in_flight;
    logic             issue_fire;
    logic             push;
    logic             pop;
    logic             job_active;

    logic [511:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   level;

    // issued - delivered covers both lines still in flight on the bus and
    // lines already sitting in the buffer, so this credit alone keeps the
    // buffer from overflowing.
    assign in_flight    = issued - delivered;
    assign AvalonRead_o = (state == ISSUE) && (issued < line_count) && (in_flight < DEPTH);
    assign issue_fire   = AvalonRead_o && !AvalonWaitReq_i;

    // Returns are only accepted while a job is running and a read is
    // outstanding; anything else is a stray beat and is dropped.
    assign job_active = (state == ISSUE) || (state == DRAIN);
    assign push       = AvalonReadDataValid_i && job_active && (received != issued);
    assign pop        = ReadValid_o && ReadAck_i;

    assign ReadValid_o = (level != '0);
    assign ReadData_o  = ReadValid_o ? mem[rd_ptr] : '0;
    assign First_o     = ReadValid_o && (delivered == 10'd0);
    assign Last_o      = ReadValid_o && (delivered == line_count - 10'd1);

    // The address is only presented while a request is on the bus, which
    // keeps it at zero when idle and stable across a waitrequest stall.
    assign AvalonAddr_o       = AvalonRead_o ? {accu, BASE + 63'(issued)} : 64'h0;
    assign AvalonLock_o       = AvalonRead_o;
    assign AvalonWrite_o      = 1'b0;
    assign AvalonByteEnable_o = {64{1'b1}};
    assign AvalonWriteData_o  = '0;

    assign Busy_o = (state != IDLE);
    assign Done_o = (state == DONE);

    // Job sequencing. An empty job passes through DRAIN for one cycle, where
    // delivered == N already holds, so it reaches DONE on its second busy
    // cycle. DRAIN looks ahead at the final handshake so that Done_o follows
    // the last accepted line by exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Start_i) begin
                    state_next = (LineCount_i == 9'd0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (issued == line_count) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((delivered == line_count) ||
                    (pop && (delivered + 10'd1 == line_count))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, job parameters, event counters and buffer pointers. Starting a
    // job clears the counters; otherwise each counter follows its own event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            line_count <= '0;
            accu       <= 1'b0;
            issued     <= '0;
            received   <= '0;
            delivered  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && Start_i) begin
                line_count <= {1'b0, LineCount_i};
                accu       <= AccuEn_i;
                issued     <= '0;
                received   <= '0;
                delivered  <= '0;
            end else begin
                if (issue_fire) begin
                    issued <= issued + 10'd1;
                end
                if (push) begin
                    received <= received + 10'd1;
                end
                if (pop) begin
                    delivered <= delivered + 10'd1;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Buffer storage needs no reset; the level counter decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= AvalonReadData_i;
        end
    end

endmodule

// File: tb/tb_core_read_master.sv
// ---------------------------------------------------------------------------
// tb_core_read_master
//
// Bench for core_read_master. A table of job descriptions (line count,
// slave latency, stall pattern, ack pattern, mid-job start/reset) is run
// against a behavioural slave, followed by randomized jobs. Expected
// behaviour comes from a line-level model: line i lives at base+i, reads
// are allowed while fewer than N were issued and fewer than FIFO_DEPTH are
// outstanding, lines come back in order one cycle after their return beat.
// A second instance with a base address near 2^63 checks address wrap.
// ---------------------------------------------------------------------------
module tb_core_read_master;

    localparam logic [63:0] BASE_ADDR = 64'h100;
    localparam logic [63:0] WRAP_ADDR = 64'hFFFF_FFFF_FFFF_FFFE;
    localparam int          DEPTH     = 8;
    localparam int          MAX_CYC   = 3000;

    typedef struct {
        int n;
        bit accu;
        int lat;
        int stall_req;
        int stall_len;
        int wait_pct;
        int ack_off;
        int ack_pct;
        int stray_pct;
        int start_at;
        int rst_after;
        int exp_reads;
        int exp_lines;
        int exp_dones;
    } job_vec_t;

    typedef struct {
        int          due;
        logic [63:0] addr;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         Start_i;
    logic [8:0]   LineCount_i;
    logic         AccuEn_i;
    logic [511:0] AvalonReadData_i;
    logic         AvalonReadDataValid_i;
    logic         AvalonWaitReq_i;
    logic         ReadAck_i;

    logic         Busy_o;
    logic         Done_o;
    logic [63:0]  AvalonAddr_o;
    logic         AvalonRead_o;
    logic         AvalonWrite_o;
    logic [63:0]  AvalonByteEnable_o;
    logic [511:0] AvalonWriteData_o;
    logic         AvalonLock_o;
    logic [511:0] ReadData_o;
    logic         ReadValid_o;
    logic         First_o;
    logic         Last_o;

    logic         w_busy;
    logic         w_done;
    logic [63:0]  w_addr;
    logic         w_read;
    logic         w_write;
    logic [63:0]  w_byte_enable;
    logic [511:0] w_write_data;
    logic         w_lock;
    logic [511:0] w_read_data;
    logic         w_read_valid;
    logic         w_first;
    logic         w_last;

    int total = 0;
    int bad   = 0;

    core_read_master #(.INITIAL_ADDR(BASE_ADDR), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .Start_i(Start_i), .LineCount_i(LineCount_i), .AccuEn_i(AccuEn_i),
        .Busy_o(Busy_o), .Done_o(Done_o),
        .AvalonAddr_o(AvalonAddr_o), .AvalonRead_o(AvalonRead_o),
        .AvalonWrite_o(AvalonWrite_o), .AvalonByteEnable_o(AvalonByteEnable_o),
        .AvalonWriteData_o(AvalonWriteData_o), .AvalonReadData_i(AvalonReadData_i),
        .AvalonReadDataValid_i(AvalonReadDataValid_i), .AvalonLock_o(AvalonLock_o),
        .AvalonWaitReq_i(AvalonWaitReq_i),
        .ReadData_o(ReadData_o), .ReadValid_o(ReadValid_o), .ReadAck_i(ReadAck_i),
        .First_o(First_o), .Last_o(Last_o)
    );

    core_read_master #(.INITIAL_ADDR(WRAP_ADDR), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst(rst),
        .Start_i(Start_i), .LineCount_i(LineCount_i), .AccuEn_i(AccuEn_i),
        .Busy_o(w_busy), .Done_o(w_done),
        .AvalonAddr_o(w_addr), .AvalonRead_o(w_read),
        .AvalonWrite_o(w_write), .AvalonByteEnable_o(w_byte_enable),
        .AvalonWriteData_o(w_write_data), .AvalonReadData_i(AvalonReadData_i),
        .AvalonReadDataValid_i(AvalonReadDataValid_i), .AvalonLock_o(w_lock),
        .AvalonWaitReq_i(AvalonWaitReq_i),
        .ReadData_o(w_read_data), .ReadValid_o(w_read_valid), .ReadAck_i(ReadAck_i),
        .First_o(w_first), .Last_o(w_last)
    );

    // Memory contents seen by the slave: every line is a distinct function
    // of its full 64-bit address.
    function automatic logic [511:0] line_data(input logic [63:0] addr);
        logic [511:0] d;
        for (int k = 0; k < 8; k++) begin
            d[k*64 +: 64] = addr ^ ({8{8'(k)}} << 4) ^ 64'hA5A5_5A5A_0F0F_F0F0;
        end
        return d;
    endfunction

    task automatic checkOutput(input string name, input logic [511:0] actual,
                               input logic [511:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [8:0] count,
                                 input logic accu, input logic wait_req,
                                 input logic valid, input logic [511:0] data,
                                 input logic ack);
        Start_i               = start;
        LineCount_i           = count;
        AccuEn_i              = accu;
        AvalonWaitReq_i       = wait_req;
        AvalonReadDataValid_i = valid;
        AvalonReadData_i      = data;
        ReadAck_i             = ack;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "-busy"},   Busy_o, 1'b0);
        checkOutput({tag, "-done"},   Done_o, 1'b0);
        checkOutput({tag, "-addr"},   AvalonAddr_o, 64'h0);
        checkOutput({tag, "-read"},   AvalonRead_o, 1'b0);
        checkOutput({tag, "-write"},  AvalonWrite_o, 1'b0);
        checkOutput({tag, "-be"},     AvalonByteEnable_o, {64{1'b1}});
        checkOutput({tag, "-wdata"},  AvalonWriteData_o, 512'h0);
        checkOutput({tag, "-lock"},   AvalonLock_o, 1'b0);
        checkOutput({tag, "-rdata"},  ReadData_o, 512'h0);
        checkOutput({tag, "-rvalid"}, ReadValid_o, 1'b0);
        checkOutput({tag, "-first"},  First_o, 1'b0);
        checkOutput({tag, "-last"},   Last_o, 1'b0);
    endtask

    // Runs one job against the slave model, checking every cycle, and
    // reports how many reads were accepted, lines delivered and Done pulses.
    task automatic runJob(input job_vec_t v, output int reads, output int lines,
                          output int dones);
        rsp_t         pend[$];
        rsp_t         r;
        int           cyc;
        int           req_idx   = 0;
        int           rx_cnt    = 0;
        int           delivered = 0;
        int           last_ack  = -10;
        int           done_cyc  = -1;
        int           stall_cnt = 0;
        bit           finished  = 0;
        bit           aborted   = 0;
        bit           legit;
        logic         read_now, wait_now, valid_now, ack_now, start_now;
        logic         exp_read, exp_valid, exp_done;
        logic         prev_stall = 1'b0;
        logic [63:0]  prev_addr  = 64'h0;
        logic [511:0] data_now;

        dones = 0;
        applyStimulus(1'b1, 9'(v.n), v.accu, 1'b0, 1'b0, '0, 1'b0);
        #1;
        checkOutput("pre-start-busy", Busy_o, 1'b0);
        @(negedge clk);
        cyc = 1;

        while (!finished && cyc < MAX_CYC) begin
            if (v.rst_after >= 0 && delivered >= v.rst_after) begin
                applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                #1;
                checkIdleOutputs("mid-reset");
                for (int i = 0; i < 6; i++) begin
                    applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b1, {16{$urandom}}, 1'b1);
                    #1;
                    checkOutput("stray-valid", ReadValid_o, 1'b0);
                    checkOutput("stray-busy", Busy_o, 1'b0);
                    @(negedge clk);
                end
                aborted  = 1;
                finished = 1;
            end else begin
                read_now = AvalonRead_o;
                if (prev_stall) begin
                    checkOutput("hold-read", read_now, 1'b1);
                    checkOutput("hold-addr", AvalonAddr_o, prev_addr);
                end
                wait_now = 1'b0;
                if (read_now) begin
                    if (v.stall_req >= 0 && req_idx == v.stall_req && stall_cnt < v.stall_len) begin
                        wait_now = 1'b1;
                        stall_cnt++;
                    end else if (int'($urandom_range(0, 99)) < v.wait_pct) begin
                        wait_now = 1'b1;
                    end
                end
                valid_now = 1'b0;
                legit     = 0;
                data_now  = {16{$urandom}};
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    valid_now = 1'b1;
                    data_now  = line_data(pend[0].addr);
                    void'(pend.pop_front());
                    legit = 1;
                end else if (pend.size() == 0 && int'($urandom_range(0, 99)) < v.stray_pct) begin
                    valid_now = 1'b1;
                end
                ack_now   = (cyc >= v.ack_off) && (int'($urandom_range(0, 99)) < v.ack_pct);
                start_now = (cyc == v.start_at) && (done_cyc < 0);
                applyStimulus(start_now, 9'(v.n + 7), ~v.accu, wait_now, valid_now, data_now, ack_now);
                #1;

                exp_read = (req_idx < v.n) && (req_idx - delivered < DEPTH);
                checkOutput("read", AvalonRead_o, exp_read);
                checkOutput("lock", AvalonLock_o, exp_read);
                if (exp_read) begin
                    checkOutput("addr", AvalonAddr_o,
                                {v.accu, 63'(BASE_ADDR) + 63'(req_idx)});
                    checkOutput("addr-wrap", w_addr,
                                {v.accu, 63'(WRAP_ADDR) + 63'(req_idx)});
                end
                exp_valid = (rx_cnt > delivered);
                checkOutput("valid", ReadValid_o, exp_valid);
                checkOutput("first", First_o, exp_valid && delivered == 0);
                checkOutput("last", Last_o, exp_valid && delivered == v.n - 1);
                if (exp_valid) begin
                    checkOutput("data", ReadData_o,
                                line_data({v.accu, 63'(BASE_ADDR) + 63'(delivered)}));
                end
                exp_done = (done_cyc < 0) &&
                           ((v.n == 0) ? (cyc == 2) : (delivered == v.n && cyc == last_ack + 1));
                checkOutput("done", Done_o, exp_done);
                checkOutput("busy", Busy_o, done_cyc < 0);
                if (Done_o) begin
                    dones++;
                end

                if (AvalonRead_o && !wait_now) begin
                    r.due  = cyc + v.lat;
                    r.addr = AvalonAddr_o;
                    pend.push_back(r);
                    req_idx++;
                end
                if (legit) begin
                    rx_cnt++;
                end
                if (ReadValid_o && ack_now) begin
                    delivered++;
                    last_ack = cyc;
                end
                if (exp_done) begin
                    done_cyc = cyc;
                end
                if (done_cyc >= 0 && cyc >= done_cyc + 3) begin
                    finished = 1;
                end
                prev_stall = AvalonRead_o && wait_now;
                prev_addr  = AvalonAddr_o;
                @(negedge clk);
                cyc++;
            end
        end

        if (!finished && !aborted) begin
            total++;
            bad++;
            $display("[TB] FAIL job-timeout: got no completion within %0d cycles, want Done", MAX_CYC);
        end
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        reads = req_idx;
        lines = delivered;
    endtask

    job_vec_t vecs[8];
    job_vec_t rv;
    int       got_reads, got_lines, got_dones;

    initial begin
        //             n  acc lat stq sln wp aoff apct str sat rsta er  el  ed
        vecs[0] = '{   4, 0,  2,  -1, 0,  0, 0,   100, 0,  -1, -1,  4,  4, 1};
        vecs[1] = '{   3, 0,  2,   1, 3,  0, 0,   100, 0,  -1, -1,  3,  3, 1};
        vecs[2] = '{  20, 0,  2,  -1, 0,  0, 30,  100, 0,  -1, -1, 20, 20, 1};
        vecs[3] = '{   2, 1,  1,  -1, 0,  0, 0,   100, 0,  -1, -1,  2,  2, 1};
        vecs[4] = '{   0, 0,  2,  -1, 0,  0, 0,   100, 0,  -1, -1,  0,  0, 1};
        vecs[5] = '{   5, 0,  3,  -1, 0,  0, 0,   100, 0,   3, -1,  5,  5, 1};
        vecs[6] = '{   6, 0,  2,  -1, 0,  0, 0,   100, 0,  -1,  2, -1,  2, 0};
        vecs[7] = '{   1, 0,  1,  -1, 0,  0, 0,   100, 0,  -1, -1,  1,  1, 1};

        rst = 1'b1;
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        checkIdleOutputs("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            $display("[TB] directed job %0d: N=%0d", i, vecs[i].n);
            runJob(vecs[i], got_reads, got_lines, got_dones);
            if (vecs[i].exp_reads >= 0) begin
                checkOutput($sformatf("job%0d-reads", i), got_reads, vecs[i].exp_reads);
            end
            checkOutput($sformatf("job%0d-lines", i), got_lines, vecs[i].exp_lines);
            checkOutput($sformatf("job%0d-dones", i), got_dones, vecs[i].exp_dones);
        end

        for (int j = 0; j < 6; j++) begin
            rv.n         = int'($urandom_range(1, 40));
            rv.accu      = 1'($urandom);
            rv.lat       = int'($urandom_range(1, 5));
            rv.stall_req = -1;
            rv.stall_len = 0;
            rv.wait_pct  = 25;
            rv.ack_off   = int'($urandom_range(0, 12));
            rv.ack_pct   = 60;
            rv.stray_pct = 20;
            rv.start_at  = int'($urandom_range(2, 10));
            rv.rst_after = -1;
            rv.exp_reads = rv.n;
            rv.exp_lines = rv.n;
            rv.exp_dones = 1;
            $display("[TB] random job %0d: N=%0d lat=%0d", j, rv.n, rv.lat);
            runJob(rv, got_reads, got_lines, got_dones);
            checkOutput($sformatf("rnd%0d-reads", j), got_reads, rv.exp_reads);
            checkOutput($sformatf("rnd%0d-lines", j), got_lines, rv.exp_lines);
            checkOutput($sformatf("rnd%0d-dones", j), got_dones, rv.exp_dones);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
